comparator_sort_ctrl: RTL and testbench

COMPARATOR_SORT_CTRL -- requirements
Module: comparator_sort_ctrl

---
 rtl/comparator_sort_ctrl_if.sv | 33 +++
 rtl/comparator_sort_ctrl.sv | 129 ++++++++++++
 tb/tb_comparator_sort_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_sort_ctrl_if.sv
// Request/result bundle for comparator_sort_ctrl: the master issues a sort of din,
// and the slave returns busy/done status with the sorted dout and its swap count.
interface comparator_sort_ctrl_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int SW = $clog2(N * (N - 1) / 2 + 1);

    logic           start;
    logic [N*W-1:0] din;
    logic           busy;
    logic           done;
    logic [N*W-1:0] dout;
    logic [SW-1:0]  swaps;

    modport master (
        output start,
        output din,
        input  busy,
        input  done,
        input  dout,
        input  swaps
    );

    modport slave (
        input  start,
        input  din,
        output busy,
        output done,
        output dout,
        output swaps
    );
endinterface

// File: rtl/comparator_sort_ctrl.sv
// Sequential bubble sort of N W-bit elements through one shared magnitude comparator,
// one compare-and-swap per cycle, with a fixed (N-1)^2-cycle compare phase.
module comparator_sort_ctrl #(
    parameter int W       = 4,
    parameter int N       = 4,
    parameter bit DESCEND = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    comparator_sort_ctrl_if.slave bus
);
    localparam int            SW   = $clog2(N * (N - 1) / 2 + 1);
    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 2);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   r [N];
    logic [IW-1:0]  j;
    logic [IW-1:0]  p;
    logic [SW-1:0]  cnt;

    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           gt;
    logic           lt;
    logic           eq;
    logic           swap_en;
    logic [W-1:0]   r_nxt [N];
    logic [N*W-1:0] r_nxt_flat;
    logic [SW-1:0]  cnt_nxt;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves
    // it unassigned (no latch), and blocking '=' is used because later lines read the
    // values written earlier in the same evaluation.
    always_comb begin
        cmp_a   = r[j];
        cmp_b   = r[j + IW'(1)];
        gt      = cmp_a > cmp_b;
        lt      = cmp_a < cmp_b;
        eq      = cmp_a == cmp_b;
        // Equal pairs never swap, which is what keeps the sort stable.
        swap_en = (state == COMPARE) && !eq && (DESCEND ? lt : gt);

        r_nxt = r;
        if (swap_en) begin
            r_nxt[j]          = cmp_b;
            r_nxt[j + IW'(1)] = cmp_a;
        end

        cnt_nxt = swap_en ? cnt + SW'(1) : cnt;

        r_nxt_flat = '0;
        for (int k = 0; k < N; k++) begin
            r_nxt_flat[k*W +: W] = r_nxt[k];
        end
    end

    // NOTE: state is updated with non-blocking '<=' so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            p         <= '0;
            cnt       <= '0;
            // NOTE: the working array is only N registers, so it is cleared on reset
            // like any other flop rather than treated as an unreset memory.
            for (int k = 0; k < N; k++) begin
                r[k] <= '0;
            end
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.dout  <= '0;
            bus.swaps <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < N; k++) begin
                            r[k] <= bus.din[k*W +: W];
                        end
                        cnt      <= '0;
                        j        <= '0;
                        p        <= '0;
                        bus.busy <= 1'b1;
                        state    <= COMPARE;
                    end
                end

                COMPARE: begin
                    for (int k = 0; k < N; k++) begin
                        r[k] <= r_nxt[k];
                    end
                    cnt <= cnt_nxt;
                    if (j == LAST) begin
                        j <= '0;
                        if (p == LAST) begin
                            // Capture the result including this cycle's compare-and-swap.
                            state     <= DONE;
                            bus.done  <= 1'b1;
                            bus.dout  <= r_nxt_flat;
                            bus.swaps <= cnt_nxt;
                        end else begin
                            p <= p + IW'(1);
                        end
                    end else begin
                        j <= j + IW'(1);
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Directed bench for comparator_sort_ctrl: an ascending and a descending instance
// driven from a vector table, plus hand-built busy/DONE-cycle and mid-sort reset sequences.
module tb_comparator_sort_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        sel;
    logic [15:0] din;

    int nchecks = 0;
    int nerrs   = 0;

    logic [15:0] prev_dout [2];
    logic [2:0]  prev_sw   [2];

    comparator_sort_ctrl_if #(.W(4), .N(4)) b0 ();
    comparator_sort_ctrl_if #(.W(4), .N(4)) b1 ();

    comparator_sort_ctrl #(.W(4), .N(4), .DESCEND(1'b0)) dut_asc (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    comparator_sort_ctrl #(.W(4), .N(4), .DESCEND(1'b1)) dut_desc (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    assign b0.start = start && !sel;
    assign b1.start = start && sel;
    assign b0.din   = din;
    assign b1.din   = din;

    logic        busy_m;
    logic        done_m;
    logic [15:0] dout_m;
    logic [2:0]  swaps_m;

    assign busy_m  = sel ? b1.busy  : b0.busy;
    assign done_m  = sel ? b1.done  : b0.done;
    assign dout_m  = sel ? b1.dout  : b0.dout;
    assign swaps_m = sel ? b1.swaps : b0.swaps;

    typedef struct packed {
        logic        desc;
        logic [15:0] din;
        logic [15:0] dout;
        logic [2:0]  swaps;
    } vec_t;

    vec_t vecs [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present d with a one-cycle start, then scramble din so late changes are exercised.
    task automatic start_sort(input logic [15:0] d);
        din   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        din   = ~d;
    endtask

    // Called in cycle T+1 of an accepted start; follows the sort through done and back to idle.
    task automatic finish_sort(input logic [15:0] exp_dout, input logic [2:0] exp_sw,
                               input string tag);
        int          t       = 1;
        bit          seen    = 1'b0;
        bit          busy_ok = 1'b1;
        bit          hold_ok = 1'b1;
        logic [15:0] pd      = prev_dout[sel];
        logic [2:0]  ps      = prev_sw[sel];
        while (!seen && t <= 20) begin
            if (done_m === 1'b1) begin
                seen = 1'b1;
                check({tag, " latency"}, 32'(t), 32'd10);
                check({tag, " busy at done"}, 32'(busy_m), 32'd1);
                check({tag, " dout"}, 32'(dout_m), 32'(exp_dout));
                check({tag, " swaps"}, 32'(swaps_m), 32'(exp_sw));
            end else begin
                if (busy_m !== 1'b1) busy_ok = 1'b0;
                if (dout_m !== pd || swaps_m !== ps) hold_ok = 1'b0;
                tick();
                t++;
            end
        end
        check({tag, " done seen within budget"}, 32'(seen), 32'd1);
        check({tag, " busy during sort"}, 32'(busy_ok), 32'd1);
        check({tag, " outputs held during sort"}, 32'(hold_ok), 32'd1);
        tick();
        check({tag, " done one cycle"}, 32'(done_m), 32'd0);
        check({tag, " busy low after done"}, 32'(busy_m), 32'd0);
        prev_dout[sel] = exp_dout;
        prev_sw[sel]   = exp_sw;
    endtask

    initial begin
        int ndone;
        int tdone;

        vecs[0] = '{desc: 1'b0, din: 16'h4231, dout: 16'h4321, swaps: 3'd1};
        vecs[1] = '{desc: 1'b0, din: 16'h1234, dout: 16'h4321, swaps: 3'd6};
        vecs[2] = '{desc: 1'b0, din: 16'h7777, dout: 16'h7777, swaps: 3'd0};
        vecs[3] = '{desc: 1'b0, din: 16'h0F0F, dout: 16'hFF00, swaps: 3'd3};
        vecs[4] = '{desc: 1'b0, din: 16'hF0F0, dout: 16'hFF00, swaps: 3'd1};
        vecs[5] = '{desc: 1'b0, din: 16'h8F10, dout: 16'hF810, swaps: 3'd1};
        vecs[6] = '{desc: 1'b0, din: 16'h0000, dout: 16'h0000, swaps: 3'd0};
        vecs[7] = '{desc: 1'b1, din: 16'h4231, dout: 16'h1234, swaps: 3'd5};
        vecs[8] = '{desc: 1'b1, din: 16'h0F0F, dout: 16'h00FF, swaps: 3'd1};
        vecs[9] = '{desc: 1'b1, din: 16'h7777, dout: 16'h7777, swaps: 3'd0};

        rst   = 1'b1;
        start = 1'b1;
        sel   = 1'b0;
        din   = 16'h1234;
        prev_dout[0] = '0;
        prev_dout[1] = '0;
        prev_sw[0]   = '0;
        prev_sw[1]   = '0;
        repeat (3) tick();

        // Reset wins over a simultaneous start.
        check("reset busy asc", 32'(b0.busy), 32'd0);
        check("reset done asc", 32'(b0.done), 32'd0);
        check("reset dout asc", 32'(b0.dout), 32'd0);
        check("reset swaps asc", 32'(b0.swaps), 32'd0);
        check("reset busy desc", 32'(b1.busy), 32'd0);
        check("reset dout desc", 32'(b1.dout), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            sel = vecs[i].desc;
            start_sort(vecs[i].din);
            finish_sort(vecs[i].dout, vecs[i].swaps, $sformatf("vec%0d", i));
        end

        // Start while busy and a din change mid-sort are ignored; start in the DONE
        // cycle is ignored; start in the following idle cycle is accepted.
        sel = 1'b0;
        start_sort(16'h4231);
        ndone = 0;
        tdone = 0;
        for (int t = 1; t <= 11; t++) begin
            if (done_m === 1'b1) begin
                ndone++;
                tdone = t;
                check("busy-seq dout", 32'(dout_m), 32'h4321);
                check("busy-seq swaps", 32'(swaps_m), 32'd1);
            end
            start = 1'b0;
            if (t == 2) din = 16'h1234;
            if (t == 4) start = 1'b1;
            if (t == 10) begin
                din   = 16'h0F0F;
                start = 1'b1;
            end
            if (t == 11) begin
                check("busy-seq idle after done", 32'(busy_m), 32'd0);
                din   = 16'h1234;
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        din   = 16'h0000;
        check("busy-seq done count", 32'(ndone), 32'd1);
        check("busy-seq done cycle", 32'(tdone), 32'd10);
        prev_dout[0] = 16'h4321;
        prev_sw[0]   = 3'd1;
        finish_sort(16'h4321, 3'd6, "restart after done");

        // Reset in the middle of a sort aborts it and clears the results.
        sel = 1'b0;
        start_sort(16'h1234);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(b0.busy), 32'd0);
        check("abort done", 32'(b0.done), 32'd0);
        check("abort dout", 32'(b0.dout), 32'd0);
        check("abort swaps", 32'(b0.swaps), 32'd0);
        check("abort dout desc", 32'(b1.dout), 32'd0);
        ndone = 0;
        repeat (15) begin
            if (done_m === 1'b1) ndone++;
            tick();
        end
        check("abort no done", 32'(ndone), 32'd0);
        prev_dout[0] = '0;
        prev_dout[1] = '0;
        prev_sw[0]   = '0;
        prev_sw[1]   = '0;
        start_sort(16'h0F0F);
        finish_sort(16'hFF00, 3'd3, "sort after abort");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
